rd_win_gen: RTL and testbench
=============================

RD_WIN_GEN -- requirements
Module: rd_win_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits.
REQ-002 The block SHALL have parameter ACK_LAT, default 2, meaning the number of cycles from the rd pulse to the rd_ack pulse; legal range is 1..15.
REQ-003 clk  input  1  Single clock; all state SHALL update on the posedge.
REQ-004 reset  input  1  Synchronous, active-high reset, sampled on the clk posedge.
REQ-005 wr_valid  input  1  Producer offers wr_data.
REQ-006 wr_data  input  WIDTH  Data word to store.
REQ-007 wr_ready  output  1  Buffer can accept a word this cycle.
REQ-008 rd_req  input  1  Consumer requests a read.
REQ-009 rd  output  1  One-cycle window-start pulse; drives the checker's start_event.
REQ-010 rd_data  output  WIDTH  Stored word; drives the checker's test_expr.
REQ-011 rd_ack  output  1  One-cycle window-end pulse; drives the checker's end_event.
REQ-012 full  output  1  Buffer holds an unconsumed word.
REQ-013 err_underflow  output  1  One-cycle pulse when rd_req arrives while the buffer is empty.

Function
REQ-014 The block SHALL be a one-entry buffer with an FSM of four states: EMPTY, FULL, WIN and ACK.
REQ-015 wr_ready SHALL be 1 only in EMPTY.
REQ-016 In EMPTY, wr_valid=1 SHALL capture wr_data into the hold register and move the FSM to FULL on the next cycle.
REQ-017 In states other than EMPTY, wr_valid SHALL be ignored: no capture, and the hold register SHALL be unchanged.
REQ-018 In FULL, rd_req=1 SHALL move the FSM to WIN.
REQ-019 rd SHALL be asserted for exactly the first cycle in WIN, i.e. one cycle after rd_req is sampled.
REQ-020 On WIN entry, a 4-bit down-counter SHALL be loaded with ACK_LAT-1.
REQ-021 The counter SHALL decrement each cycle in WIN.
REQ-022 The FSM SHALL move to ACK in the cycle after the counter reads 0.
REQ-023 rd_ack SHALL be 1 for exactly the single cycle in ACK.
REQ-024 The FSM SHALL then return to EMPTY.
REQ-025 The rd to rd_ack spacing SHALL be exactly ACK_LAT cycles, measured from the posedge where rd is first seen high to the posedge where rd_ack is first seen high.
REQ-026 rd_data SHALL equal the hold register at all times.
REQ-027 rd_data SHALL NOT change from the cycle rd is high through the cycle rd_ack is high, inclusive.
REQ-028 rd_data SHALL retain its last value after ACK; there is no clearing on consume.
REQ-029 full SHALL be 1 in FULL, WIN and ACK.
REQ-030 full SHALL be 0 in EMPTY.
REQ-031 rd_req in EMPTY SHALL pulse err_underflow for one cycle, registered, in the next cycle; the FSM SHALL stay in EMPTY.
REQ-032 rd_req in WIN or ACK SHALL be ignored, with no error and no queuing.
REQ-033 A write cannot be accepted in the ACK cycle; the earliest new capture SHALL be the first EMPTY cycle after ACK.
REQ-034 rd and rd_ack SHALL never be high in the same cycle; this holds by construction because ACK_LAT >= 1.
REQ-035 rd, rd_ack and err_underflow SHALL be registered outputs with no combinational path from any input.
REQ-036 For ACK_LAT outside 1..15, the block SHALL raise an elaboration-time $error.

Reset
REQ-037 While reset=1 at a posedge, the FSM SHALL go to EMPTY and the counter SHALL clear to 0.
REQ-038 While reset=1 at a posedge, the hold register SHALL clear to 0, so rd_data=0.
REQ-039 While reset=1 at a posedge, rd, rd_ack, err_underflow and full SHALL be 0, and wr_ready SHALL be 1 from the next cycle.
REQ-040 Reset asserted mid-window (WIN or ACK) SHALL abort the window: no rd_ack SHALL be issued for the aborted read, and the stored word SHALL be discarded.
REQ-041 After reset deasserts, the first posedge SHALL sample inputs normally.

Verification
REQ-042 Basic read, ACK_LAT=2: write 8'hA5, then rd_req -> rd high 1 cycle; rd_ack high exactly 2 cycles later; rd_data=8'hA5 throughout; checker passes; full drops after ACK.
REQ-043 Latency sweep over ACK_LAT = 1, 2, 7, 15 -> rd to rd_ack spacing equals ACK_LAT in every case; rd and rd_ack each 1 cycle wide.
REQ-044 Blocked write: while in WIN, drive wr_valid=1 with wr_data=8'h3C -> wr_ready=0, rd_data stays 8'hA5, checker passes.
REQ-045 Underflow and ignored read: rd_req in EMPTY -> err_underflow pulses once, no rd; second rd_req during WIN -> no second rd, no error.
REQ-046 Reset mid-window: reset=1 one cycle after rd -> no rd_ack; rd_data=0; full=0; wr_ready=1 after reset releases.
REQ-047 Back-to-back operation: write, read to ACK, write 8'h5A on the first EMPTY cycle, read again -> two full windows, with data 8'hA5 then 8'h5A.

Source files
------------

// File: rtl/rd_win_if.sv
// Read-window buffer bus.
// Groups the producer write handshake, the consumer read request and the
// window outputs (rd / rd_data / rd_ack) plus status flags.
//   master : the environment side (drives wr_valid, wr_data, rd_req)
//   slave  : the buffer side (drives wr_ready, rd, rd_data, rd_ack, full, err_underflow)
interface rd_win_if #(
  parameter int unsigned WIDTH = 8
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_req;
  logic             rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ack;
  logic             full;
  logic             err_underflow;

  modport master (
    output wr_valid, wr_data, rd_req,
    input  wr_ready, rd, rd_data, rd_ack, full, err_underflow
  );

  modport slave (
    input  wr_valid, wr_data, rd_req,
    output wr_ready, rd, rd_data, rd_ack, full, err_underflow
  );
endinterface

// File: rtl/rd_win_gen.sv
// One-entry buffer that frames each consumed word with a read window:
// rd pulses on the first window cycle, rd_ack pulses exactly ACK_LAT cycles
// later, and rd_data is held stable across the whole window.
// Ports:
//   clk   : single clock, all state updates on posedge
//   reset : synchronous active-high reset
//   bus   : rd_win_if slave modport (write handshake, read request, window
//           pulses, stored data, full flag, underflow error pulse)
module rd_win_gen #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ACK_LAT = 2
) (
  input logic       clk,
  input logic       reset,
  rd_win_if.slave   bus
);

  if (ACK_LAT == 0 || ACK_LAT > 15) begin : g_bad_ack_lat
    $error("rd_win_gen: ACK_LAT=%0d outside legal range 1..15", ACK_LAT);
  end

  localparam logic [3:0] LoadVal = 4'(ACK_LAT - 1);

  typedef enum logic [1:0] {StEmpty, StFull, StWin, StAck} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             rd_q, rd_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  // State register, including the registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      cnt_q   <= 4'd0;
      hold_q  <= '0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The counter is loaded on WIN entry so that WIN lasts
  // ACK_LAT cycles; ACK follows the cycle in which the counter reads 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StEmpty: begin
        if (bus.wr_valid) begin
          hold_d  = bus.wr_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (bus.rd_req) begin
          cnt_d   = LoadVal;
          state_d = StWin;
        end
      end
      StWin: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StEmpty;
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  // Output logic. Pulse outputs are computed one cycle early and registered
  // so rd lands on the first WIN cycle and rd_ack on the ACK cycle.
  always_comb begin
    rd_d  = (state_q == StFull) && bus.rd_req;
    ack_d = (state_q == StWin) && (cnt_q == 4'd0);
    err_d = (state_q == StEmpty) && bus.rd_req;
  end

  assign bus.wr_ready      = (state_q == StEmpty);
  assign bus.full          = (state_q != StEmpty);
  assign bus.rd            = rd_q;
  assign bus.rd_ack        = ack_q;
  assign bus.err_underflow = err_q;
  assign bus.rd_data       = hold_q;

endmodule

// File: tb/tb_rd_win_gen.sv
module tb_rd_win_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rd_win_if #(.WIDTH(8)) if1 ();
  rd_win_if #(.WIDTH(8)) if2 ();
  rd_win_if #(.WIDTH(8)) if7 ();
  rd_win_if #(.WIDTH(8)) if15 ();

  // Shared stimulus into all four buses.
  assign if1.wr_valid  = wr_valid;
  assign if1.wr_data   = wr_data;
  assign if1.rd_req    = rd_req;
  assign if2.wr_valid  = wr_valid;
  assign if2.wr_data   = wr_data;
  assign if2.rd_req    = rd_req;
  assign if7.wr_valid  = wr_valid;
  assign if7.wr_data   = wr_data;
  assign if7.rd_req    = rd_req;
  assign if15.wr_valid = wr_valid;
  assign if15.wr_data  = wr_data;
  assign if15.rd_req   = rd_req;

  rd_win_gen #(.WIDTH(8), .ACK_LAT(1))  u_lat1  (.clk(clk), .reset(reset), .bus(if1));
  rd_win_gen #(.WIDTH(8), .ACK_LAT(2))  u_dut   (.clk(clk), .reset(reset), .bus(if2));
  rd_win_gen #(.WIDTH(8), .ACK_LAT(7))  u_lat7  (.clk(clk), .reset(reset), .bus(if7));
  rd_win_gen #(.WIDTH(8), .ACK_LAT(15)) u_lat15 (.clk(clk), .reset(reset), .bus(if15));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lat [4];
    int rd_k [4];
    int ack_k [4];
    int rd_n [4];
    int ack_n [4];
    logic [3:0] rdv;
    logic [3:0] ackv;

    lat = '{1, 2, 7, 15};
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state.
    chk("rst_rd",      {31'd0, if2.rd}, 32'd0);
    chk("rst_ack",     {31'd0, if2.rd_ack}, 32'd0);
    chk("rst_err",     {31'd0, if2.err_underflow}, 32'd0);
    chk("rst_full",    {31'd0, if2.full}, 32'd0);
    chk("rst_wrready", {31'd0, if2.wr_ready}, 32'd1);
    chk("rst_data",    {24'd0, if2.rd_data}, 32'h0);

    // Basic read with ACK_LAT=2.
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("wr_full",    {31'd0, if2.full}, 32'd1);
    chk("wr_wrready", {31'd0, if2.wr_ready}, 32'd0);
    chk("wr_data",    {24'd0, if2.rd_data}, 32'hA5);
    rd_req = 1'b1;
    step();
    chk("b_rd_hi",  {31'd0, if2.rd}, 32'd1);
    chk("b_ack_lo", {31'd0, if2.rd_ack}, 32'd0);
    chk("b_data0",  {24'd0, if2.rd_data}, 32'hA5);
    rd_req = 1'b0;
    // Blocked write while in the window.
    wr_valid = 1'b1; wr_data = 8'h3C;
    step();
    chk("b_rd_lo",     {31'd0, if2.rd}, 32'd0);
    chk("b_ack_lo1",   {31'd0, if2.rd_ack}, 32'd0);
    chk("blk_wrready", {31'd0, if2.wr_ready}, 32'd0);
    chk("blk_data",    {24'd0, if2.rd_data}, 32'hA5);
    step();
    chk("b_ack_hi",  {31'd0, if2.rd_ack}, 32'd1);
    chk("b_ack_full", {31'd0, if2.full}, 32'd1);
    chk("b_ack_data", {24'd0, if2.rd_data}, 32'hA5);
    chk("ack_wrready", {31'd0, if2.wr_ready}, 32'd0);
    step();
    // Write offered during ACK must not have been captured.
    chk("post_ack",      {31'd0, if2.rd_ack}, 32'd0);
    chk("post_full",     {31'd0, if2.full}, 32'd0);
    chk("post_data",     {24'd0, if2.rd_data}, 32'hA5);
    chk("post_wrready",  {31'd0, if2.wr_ready}, 32'd1);

    // Back-to-back: write 5A on the first EMPTY cycle, then read again.
    wr_data = 8'h5A;
    step();
    wr_valid = 1'b0;
    chk("b2b_data", {24'd0, if2.rd_data}, 32'h5A);
    chk("b2b_full", {31'd0, if2.full}, 32'd1);
    rd_req = 1'b1;
    step();
    chk("b2b_rd", {31'd0, if2.rd}, 32'd1);
    chk("b2b_rddata", {24'd0, if2.rd_data}, 32'h5A);
    // Second rd_req held during WIN is ignored.
    step();
    chk("ign_rd",  {31'd0, if2.rd}, 32'd0);
    chk("ign_err", {31'd0, if2.err_underflow}, 32'd0);
    rd_req = 1'b0;
    step();
    chk("b2b_ack",     {31'd0, if2.rd_ack}, 32'd1);
    chk("b2b_ackdata", {24'd0, if2.rd_data}, 32'h5A);
    chk("b2b_ackerr",  {31'd0, if2.err_underflow}, 32'd0);
    step();
    chk("b2b_end_ack",  {31'd0, if2.rd_ack}, 32'd0);
    chk("b2b_end_full", {31'd0, if2.full}, 32'd0);

    // Underflow in EMPTY.
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("uf_err",  {31'd0, if2.err_underflow}, 32'd1);
    chk("uf_rd",   {31'd0, if2.rd}, 32'd0);
    chk("uf_full", {31'd0, if2.full}, 32'd0);
    step();
    chk("uf_err_once", {31'd0, if2.err_underflow}, 32'd0);
    chk("uf_rd2",      {31'd0, if2.rd}, 32'd0);

    // Reset one cycle after rd aborts the window.
    wr_valid = 1'b1; wr_data = 8'hC3;
    step();
    wr_valid = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("ab_rd", {31'd0, if2.rd}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ab_ack",     {31'd0, if2.rd_ack}, 32'd0);
    chk("ab_data",    {24'd0, if2.rd_data}, 32'h0);
    chk("ab_full",    {31'd0, if2.full}, 32'd0);
    chk("ab_wrready", {31'd0, if2.wr_ready}, 32'd1);
    step();
    chk("ab_ack2", {31'd0, if2.rd_ack}, 32'd0);
    step();
    chk("ab_ack3", {31'd0, if2.rd_ack}, 32'd0);
    chk("ab_full3", {31'd0, if2.full}, 32'd0);
    // First posedge after reset samples inputs normally.
    wr_valid = 1'b1; wr_data = 8'h11;
    step();
    wr_valid = 1'b0;
    chk("rr_data", {24'd0, if2.rd_data}, 32'h11);
    chk("rr_full", {31'd0, if2.full}, 32'd1);

    // Latency sweep across all four instances.
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_k[i] = -1; ack_k[i] = -1; rd_n[i] = 0; ack_n[i] = 0;
    end
    for (int k = 0; k <= 20; k++) begin
      rdv  = {if15.rd, if7.rd, if2.rd, if1.rd};
      ackv = {if15.rd_ack, if7.rd_ack, if2.rd_ack, if1.rd_ack};
      for (int i = 0; i < 4; i++) begin
        if (rdv[i]) begin
          rd_n[i]++;
          if (rd_k[i] < 0) rd_k[i] = k;
        end
        if (ackv[i]) begin
          ack_n[i]++;
          if (ack_k[i] < 0) ack_k[i] = k;
        end
      end
      if (k < 20) step();
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sw%0d_spacing", lat[i]), 32'(ack_k[i] - rd_k[i]), 32'(lat[i]));
      chk($sformatf("sw%0d_rd_w", lat[i]), 32'(rd_n[i]), 32'd1);
      chk($sformatf("sw%0d_ack_w", lat[i]), 32'(ack_n[i]), 32'd1);
    end
    chk("sw_full_end", {28'd0, if15.full, if7.full, if2.full, if1.full}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
